dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Data-memory responder: the slave end of the core's load/store request interface (req, wr_en, mask, mem_addr, w_data in; read data out).
- Holds a DEPTH x 32 word array with byte-lane write enables.
- Services one transaction at a time through a small FSM, with a configurable number of wait states.
- Returns a one-cycle r_valid acknowledge for every read and every write.

Parameters:
DEPTH, 4096, number of 32-bit words; power of two, 2..16384
WAIT_CYCLES, 0, extra wait states inserted between accept and response; 0..15

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
req  input  1  transaction request; accepted only when ready=1
wr_en  input  1  1=write, 0=read; sampled with req
mask  input  4  byte-lane write enables; bit i covers w_data[8i+7:8i]
mem_addr  input  14  word address
w_data  input  32  write data
ready  output  1  responder idle, can accept req this cycle
r_valid  output  1  one-cycle response/acknowledge pulse
r_data  output  32  read data; for writes, word contents before the write
err  output  1  address-range error, qualified by r_valid (see Optional Feature)

Behaviour:
- Reset is asynchronous, active-low.
  - rst=0 forces state=IDLE, ready=1, r_valid=0, r_data=0, err=0, wait counter=0, captured request cleared.
  - Array contents are not reset.
- States: IDLE, WAIT, RESP. ready=1 only in IDLE.
- IDLE:
  - On a clock edge with req=1 and ready=1, capture mem_addr, wr_en, mask, w_data.
  - If WAIT_CYCLES==0, go to RESP. Otherwise go to WAIT with counter=WAIT_CYCLES.
- WAIT:
  - Counter decrements each edge.
  - Counter==1 at an edge: go to RESP.
  - Input req is ignored; the requester holds its request until ready.
- RESP entry edge:
  - r_data <= array[index].
  - err set per Optional Feature.
  - r_valid=1 for exactly the RESP cycle.
- RESP exit edge:
  - For a write, each byte i with captured mask[i]=1 is updated from captured w_data.
  - Next state is always IDLE.
- Latency: request accepted at edge N; r_valid high in cycle N+1+WAIT_CYCLES.
  - Next accept is possible at the earliest at edge N+2+WAIT_CYCLES.
- r_data holds its value after RESP until the next RESP entry. It is never cleared by idle cycles.
- Reads ignore mask and return the full word.
- Write with mask=0000: array unchanged, still acknowledged.
- Index = mem_addr[log2(DEPTH)-1:0]. Upper address bits wrap unless the feature below is enabled.
- Read-after-write: a read accepted after a write's RESP observes the written data.
- Reset asserted in WAIT or RESP: the transaction is dropped, no array write occurs, no r_valid is produced.
- req held high across RESP into IDLE is treated as a new request at the first IDLE edge. The requester must drop req after r_valid if no new transaction is intended.

Optional Feature:
Macro DMEM_BOUNDS_CHECK_EN.
- Defined: a captured mem_addr >= DEPTH is an error.
  - In RESP: err=1, r_data=0.
  - The write, if any, is suppressed; the array is unchanged.
  - err is 0 for all in-range accesses and is updated only at RESP entry.
- Undefined:
  - err is tied to 0.
  - Out-of-range addresses wrap modulo DEPTH and behave as normal accesses.

Test Plan:
- Reset with rst=0 for 3 cycles, then release -> ready=1, r_valid=0, r_data=0x00000000, err=0.
- WAIT_CYCLES=0:
  - Write 0xDEADBEEF to addr 5, mask=1111, accepted at edge N -> r_valid high in cycle N+1 only.
  - Then read addr 5 -> r_data=0xDEADBEEF with r_valid.
- Byte-mask write:
  - Over 0xDEADBEEF at addr 5, write 0x11223344 with mask=0101 -> write ack r_data=0xDEADBEEF.
  - Subsequent read of addr 5 returns 0xDE22BE44.
  - A mask=0000 write is acknowledged and leaves 0xDE22BE44.
- WAIT_CYCLES=3:
  - Read accepted at edge N -> ready=0 for cycles N+1..N+4, r_valid only in cycle N+4.
  - Extra req pulses during busy produce no additional r_valid.
- Reset mid-operation: write 0x0 to addr 7 (holding 0xCAFEF00D), rst pulsed low during WAIT -> no r_valid; a later read of addr 7 returns 0xCAFEF00D.
- DEPTH=4096, read of mem_addr=4096:
  - With DMEM_BOUNDS_CHECK_EN: err=1, r_data=0 with r_valid; a write to 4096 leaves addr 0 unchanged.
  - Without it: err=0, and the access wraps to addr 0.

Source files
------------

// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_if
// Purpose  : Load/store request bus between the core (master) and data memory.
// Revision : 1.0
// ============================================================================
interface dmem_if;
  logic        req;
  logic        wr_en;
  logic [3:0]  mask;
  logic [13:0] mem_addr;
  logic [31:0] w_data;
  logic        ready;
  logic        r_valid;
  logic [31:0] r_data;
  logic        err;

  modport master (
    output req, wr_en, mask, mem_addr, w_data,
    input  ready, r_valid, r_data, err
  );

  modport slave (
    input  req, wr_en, mask, mem_addr, w_data,
    output ready, r_valid, r_data, err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : DEPTH x 32 byte-maskable data memory, one transaction at a time
//            with WAIT_CYCLES wait states. Define DMEM_BOUNDS_CHECK_EN to flag
//            and suppress accesses with mem_addr >= DEPTH.
// Revision : 1.0
// ============================================================================
module dmem_responder #(
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 0
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int          c_IDX_W = $clog2(DEPTH);
  localparam logic [3:0]  c_WAIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic [13:0]  r_addr;
  logic         r_wr_en;
  logic [3:0]   r_mask;
  logic [31:0]  r_wdata;
  logic         r_ready;
  logic         r_rvalid;
  logic [31:0]  r_rdata;
  logic         r_err;

  logic [31:0]  mem [DEPTH];

  logic [13:0]        w_rd_addr;
  logic [c_IDX_W-1:0] w_rd_idx;
  logic [c_IDX_W-1:0] w_wr_idx;
  logic               w_entry;
  logic               w_we;
  logic               w_rd_oob;
  logic               w_wr_oob;

  // With no wait states the RESP entry edge is the accept edge itself, so the
  // array is read straight from the bus address rather than the captured one.
  assign w_rd_addr = (r_state == S_IDLE) ? bus.mem_addr : r_addr;
  assign w_rd_idx  = w_rd_addr[c_IDX_W-1:0];
  assign w_wr_idx  = r_addr[c_IDX_W-1:0];

  assign w_entry = ((r_state == S_IDLE) && bus.req && (WAIT_CYCLES == 0)) ||
                   ((r_state == S_WAIT) && (r_cnt == 4'd1));

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic [14:0] c_DEPTH_EXT = 15'(DEPTH);
  assign w_rd_oob = ({1'b0, w_rd_addr} >= c_DEPTH_EXT);
  assign w_wr_oob = ({1'b0, r_addr}    >= c_DEPTH_EXT);
`else
  logic w_unused_addr;
  assign w_unused_addr = ^{bus.mem_addr, r_addr};
  assign w_rd_oob      = 1'b0;
  assign w_wr_oob      = 1'b0;
`endif

  assign w_we = (r_state == S_RESP) && r_wr_en && !w_wr_oob;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= 14'd0;
      r_wr_en  <= 1'b0;
      r_mask   <= 4'd0;
      r_wdata  <= 32'd0;
      r_ready  <= 1'b1;
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_addr  <= bus.mem_addr;
            r_wr_en <= bus.wr_en;
            r_mask  <= bus.mask;
            r_wdata <= bus.w_data;
            r_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= c_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase

      // r_data/err only change here, so they hold between responses.
      if (w_entry) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_oob ? 32'd0 : mem[w_rd_idx];
        r_err    <= w_rd_oob;
      end
    end
  end

  // Array has no reset; an async reset during WAIT/RESP forces IDLE so w_we drops.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (r_mask[i]) begin
          mem[w_wr_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.ready   = r_ready;
  assign bus.r_valid = r_rvalid;
  assign bus.r_data  = r_rdata;
  assign bus.err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Scoreboard bench for dmem_responder, zero- and three-wait-state
//            instances side by side.
// Revision : 1.0
// ============================================================================
module tb_dmem_responder;

  logic clk;
  logic rst;

  dmem_if bus0();
  dmem_if bus3();

  dmem_responder #(.DEPTH(4096), .WAIT_CYCLES(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  dmem_responder #(.DEPTH(4096), .WAIT_CYCLES(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
    logic        dc;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  always @(negedge clk) begin
    exp_t ent;
    if (bus0.r_valid === 1'b1) begin
      if (q0.size() == 0) fail_now("dut0 unexpected r_valid");
      else begin
        ent = q0.pop_front();
        if (!ent.dc) chk("dut0 r_data", bus0.r_data, ent.d);
        chk("dut0 err", {31'd0, bus0.err}, {31'd0, ent.e});
      end
    end
    if (bus3.r_valid === 1'b1) begin
      if (q3.size() == 0) fail_now("dut3 unexpected r_valid");
      else begin
        ent = q3.pop_front();
        if (!ent.dc) chk("dut3 r_data", bus3.r_data, ent.d);
        chk("dut3 err", {31'd0, bus3.err}, {31'd0, ent.e});
      end
    end
  end

  function automatic logic rdy(input int d);
    return (d == 0) ? bus0.ready : bus3.ready;
  endfunction

  // Waits for ready, drives one request, returns 1 ns after the accept edge.
  task automatic send(input int d, input bit wr, input logic [13:0] a,
                      input logic [3:0] m, input logic [31:0] wd,
                      input bit push, input logic [31:0] ed, input bit ee,
                      input bit dc);
    int n;
    exp_t ent;
    n = 0;
    while (!rdy(d) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) fail_now("ready timeout");
    ent.d  = ed;
    ent.e  = ee;
    ent.dc = dc;
    if (d == 0) begin
      bus0.req = 1'b1; bus0.wr_en = wr; bus0.mask = m; bus0.mem_addr = a; bus0.w_data = wd;
      if (push) q0.push_back(ent);
    end else begin
      bus3.req = 1'b1; bus3.wr_en = wr; bus3.mask = m; bus3.mem_addr = a; bus3.w_data = wd;
      if (push) q3.push_back(ent);
    end
    @(posedge clk);
    #1;
    if (d == 0) bus0.req = 1'b0;
    else        bus3.req = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    while (((d == 0) ? q0.size() : q3.size()) != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) fail_now("response timeout");
  endtask

  task automatic txn(input int d, input bit wr, input logic [13:0] a,
                     input logic [3:0] m, input logic [31:0] wd,
                     input logic [31:0] ed, input bit ee, input bit dc);
    send(d, wr, a, m, wd, 1'b1, ed, ee, dc);
    wait_done(d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.req = 1'b0; bus0.wr_en = 1'b0; bus0.mask = 4'd0; bus0.mem_addr = 14'd0; bus0.w_data = 32'd0;
    bus3.req = 1'b0; bus3.wr_en = 1'b0; bus3.mask = 4'd0; bus3.mem_addr = 14'd0; bus3.w_data = 32'd0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst dut0 ready",   {31'd0, bus0.ready},   32'd1);
    chk("rst dut0 r_valid", {31'd0, bus0.r_valid}, 32'd0);
    chk("rst dut0 r_data",  bus0.r_data,           32'd0);
    chk("rst dut0 err",     {31'd0, bus0.err},     32'd0);
    chk("rst dut3 ready",   {31'd0, bus3.ready},   32'd1);
    chk("rst dut3 r_valid", {31'd0, bus3.r_valid}, 32'd0);
    chk("rst dut3 r_data",  bus3.r_data,           32'd0);
    chk("rst dut3 err",     {31'd0, bus3.err},     32'd0);

    // Zero wait states: ack in the cycle right after the accept edge only.
    send(0, 1'b1, 14'd5, 4'b1111, 32'hDEADBEEF, 1'b1, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("w0 r_valid cycle N+1", {31'd0, bus0.r_valid}, 32'd1);
    @(negedge clk);
    chk("w0 r_valid cycle N+2", {31'd0, bus0.r_valid}, 32'd0);
    wait_done(0);

    txn(0, 1'b0, 14'd5, 4'b0000, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
    txn(0, 1'b1, 14'd5, 4'b0101, 32'h11223344, 32'hDEADBEEF, 1'b0, 1'b0);
    txn(0, 1'b0, 14'd5, 4'b0000, 32'h0,        32'hDE22BE44, 1'b0, 1'b0);
    txn(0, 1'b1, 14'd5, 4'b0000, 32'hFFFFFFFF, 32'hDE22BE44, 1'b0, 1'b0);
    txn(0, 1'b0, 14'd5, 4'b1111, 32'h0,        32'hDE22BE44, 1'b0, 1'b0);

    // Address 4096 against the word at address 0.
    txn(0, 1'b1, 14'd0, 4'b1111, 32'h01234567, 32'd0, 1'b0, 1'b1);
`ifdef DMEM_BOUNDS_CHECK_EN
    txn(0, 1'b0, 14'd4096, 4'b0000, 32'h0,        32'h00000000, 1'b1, 1'b0);
    txn(0, 1'b1, 14'd4096, 4'b1111, 32'hAAAAAAAA, 32'h00000000, 1'b1, 1'b0);
    txn(0, 1'b0, 14'd0,    4'b0000, 32'h0,        32'h01234567, 1'b0, 1'b0);
`else
    txn(0, 1'b0, 14'd4096, 4'b0000, 32'h0,        32'h01234567, 1'b0, 1'b0);
    txn(0, 1'b1, 14'd4096, 4'b1111, 32'hAAAAAAAA, 32'h01234567, 1'b0, 1'b0);
    txn(0, 1'b0, 14'd0,    4'b0000, 32'h0,        32'hAAAAAAAA, 1'b0, 1'b0);
`endif

    // Three wait states: busy N+1..N+4, ack only in N+4, stray reqs ignored.
    txn(3, 1'b1, 14'd7, 4'b1111, 32'hCAFEF00D, 32'd0, 1'b0, 1'b1);
    send(3, 1'b0, 14'd7, 4'b0000, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("w3 ready cycle N+%0d", k),   {31'd0, bus3.ready},   32'd0);
      chk($sformatf("w3 r_valid cycle N+%0d", k), {31'd0, bus3.r_valid}, (k == 4) ? 32'd1 : 32'd0);
      bus3.req = (k == 1 || k == 3);
    end
    @(negedge clk);
    chk("w3 ready cycle N+5",   {31'd0, bus3.ready},   32'd1);
    chk("w3 r_valid cycle N+5", {31'd0, bus3.r_valid}, 32'd0);
    wait_done(3);

    // Reset during WAIT drops the pending write and its ack.
    send(3, 1'b1, 14'd7, 4'b1111, 32'h00000000, 1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst-mid r_valid", {31'd0, bus3.r_valid}, 32'd0);
    end
    chk("rst-mid ready", {31'd0, bus3.ready}, 32'd1);
    txn(3, 1'b0, 14'd7, 4'b0000, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("dut0 pending responses", q0.size(), 32'd0);
    chk("dut3 pending responses", q3.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
